// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO result registers (MIPS-style MULT/DIV/MTHI/MTLO).
// Latency: MULT_CYCLES (mul/madd) or DIV_CYCLES (div) busy cycles; MTHI/MTLO take effect on the issue edge.
// Backpressure: start is ignored while busy=1; the issuer retries once busy drops.
//
// Optional feature macro: MDU_MADD_EN (enables op 6 MADD / op 7 MADDU accumulate).
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   start - issue strobe; accepted when busy=0
//   op    - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
//   a, b  - rs / rt operands
//   busy  - high while a multiply or divide is in flight
//   hi/lo - HI and LO registers, straight from flops
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LP_MULT_CNT = 6'(MULT_CYCLES);
  localparam logic [5:0] LP_DIV_CNT  = 6'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic w_accept;
  logic w_is_long;
  logic w_is_div_in;
  logic w_done;

  assign w_accept    = start && (r_state == S_IDLE);
  assign w_is_div_in = (op == 3'd2) || (op == 3'd3);
`ifdef MDU_MADD_EN
  assign w_is_long   = (op <= 3'd3) || (op == 3'd6) || (op == 3'd7);
`else
  assign w_is_long   = (op <= 3'd3);
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_long) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == 6'd1)         w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy   = (r_state == S_RUN);
    w_done = (r_state == S_RUN) && (r_cnt == 6'd1);
  end

  // Counter and latched operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 6'd0;
      r_op  <= 3'd0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept && w_is_long) begin
      r_cnt <= w_is_div_in ? LP_DIV_CNT : LP_MULT_CNT;
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 6'd1;
    end
  end

  // Datapath evaluated from the latched operands; only consumed on w_done.
  logic             w_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_signed = (r_op == 3'd0) || (r_op == 3'd2) || (r_op == 3'd6);

  // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
  assign w_a_ext = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_b_ext = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Sign-magnitude divide: the most-negative dividend's magnitude still fits
  // unsigned, so MIN / -1 naturally yields quotient MIN, remainder 0.
  assign w_a_neg = w_signed && r_a[WIDTH-1];
  assign w_b_neg = w_signed && r_b[WIDTH-1];
  assign w_a_abs = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_abs = w_b_neg ? (~r_b + 1'b1) : r_b;
  assign w_q_mag = w_a_abs / w_b_abs;
  assign w_r_mag = w_a_abs % w_b_abs;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_rem   = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {r_hi, r_lo} + w_prod;
`endif

  // HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      case (r_op)
        3'd0, 3'd1: {r_hi, r_lo} <= w_prod;
        3'd2, 3'd3: begin
          if (r_b != '0) begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end
        end
`ifdef MDU_MADD_EN
        3'd6, 3'd7: {r_hi, r_lo} <= w_acc;
`endif
        default: ;
      endcase
    end else if (w_accept) begin
      if (op == 3'd4) r_hi <= a;
      if (op == 3'd5) r_lo <= a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences, then random ops checked against a behavioural model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: results from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] hi_i, input logic [31:0] lo_i,
                       output logic [31:0] hi_o, output logic [31:0] lo_o, output int cyc);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    hi_o = hi_i;
    lo_o = lo_i;
    cyc  = 0;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (o)
      3'd0: begin up = longint'(sa * sb); {hi_o, lo_o} = up; cyc = 5; end
      3'd1: begin up = ua * ub; {hi_o, lo_o} = up; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (bv != 0) begin
          sq = sa / sb; sr = sa % sb;
          lo_o = sq[31:0]; hi_o = sr[31:0];
        end
      end
      3'd3: begin
        cyc = 10;
        if (bv != 0) begin lo_o = 32'(ua / ub); hi_o = 32'(ua % ub); end
      end
      3'd4: hi_o = av;
      3'd5: lo_o = av;
`ifdef MDU_MADD_EN
      3'd6: begin up = {hi_i, lo_i} + longint'(sa * sb); {hi_o, lo_o} = up; cyc = 5; end
      3'd7: begin up = {hi_i, lo_i} + ua * ub; {hi_o, lo_o} = up; cyc = 5; end
`endif
      default: ;
    endcase
  endtask

  // Drive one op, count busy cycles (bounded), capture hi/lo on the first cycle after issue.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output int cyc, output logic [31:0] h1, output logic [31:0] l1);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    h1 = hi; l1 = lo;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  vec_t        vt[$];
  logic [31:0] m_hi, m_lo, e_hi, e_lo, h1, l1;
  int          cyc, e_cyc;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #3;
    check_int("reset_busy", int'(busy), 0);
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    vt.push_back('{"mult_neg",   3'd0, 32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA});
    vt.push_back('{"div_neg",    3'd2, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{"divu_zero",  3'd3, 32'h7,        32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{"mtlo",       3'd5, 32'hDEADBEEF, 32'h0,        0,  32'hFFFFFFFF, 32'hDEADBEEF});
    vt.push_back('{"mthi",       3'd4, 32'h1,        32'h0,        0,  32'h1,        32'hDEADBEEF});
    vt.push_back('{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0,        32'h80000000});
    vt.push_back('{"divu_big",   3'd3, 32'hFFFFFFFF, 32'h10,       10, 32'hF,        32'h0FFFFFFF});
    vt.push_back('{"div_negb",   3'd2, 32'h7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD});
    vt.push_back('{"multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{"mthi_0",     3'd4, 32'h0,        32'h0,        0,  32'h0,        32'h00000001});
    vt.push_back('{"mtlo_ones",  3'd5, 32'hFFFFFFFF, 32'h0,        0,  32'h0,        32'hFFFFFFFF});
`ifdef MDU_MADD_EN
    vt.push_back('{"maddu",      3'd7, 32'h1,        32'h1,        5,  32'h1,        32'h0});
`else
    vt.push_back('{"maddu_nop",  3'd7, 32'h1,        32'h1,        0,  32'h0,        32'hFFFFFFFF});
`endif

    m_hi = 32'h0; m_lo = 32'h0;
    for (int i = 0; i < vt.size(); i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, cyc, h1, l1);
      if (vt[i].cyc > 0) begin
        check32({vt[i].name, "_hold_hi"}, h1, m_hi);
        check32({vt[i].name, "_hold_lo"}, l1, m_lo);
      end
      check_int({vt[i].name, "_busy"}, cyc, vt[i].cyc);
      check32({vt[i].name, "_hi"}, hi, vt[i].hi);
      check32({vt[i].name, "_lo"}, lo, vt[i].lo);
      m_hi = vt[i].hi; m_lo = vt[i].lo;
    end

    // MTHI raised during busy cycle 2 of a MULTU must be ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    @(negedge clk);
    cyc++;
    start = 1'b1; op = 3'd4; a = 32'h55555555;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check_int("multu_ign_busy", cyc, 5);
    check32("multu_ign_hi", hi, 32'h0B00EA4E);
    check32("multu_ign_lo", lo, 32'h242D2080);
    check_int("multu_ign_idle", int'(busy), 0);
    m_hi = 32'h0B00EA4E; m_lo = 32'h242D2080;

    // Random ops against the model; back-to-back issue every time.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 17));
        3: rb = -32'($urandom_range(1, 17));
        default: ;
      endcase
      model(ro, ra, rb, m_hi, m_lo, e_hi, e_lo, e_cyc);
      issue(ro, ra, rb, cyc, h1, l1);
      if (e_cyc > 0) begin
        check32("rnd_hold_hi", h1, m_hi);
        check32("rnd_hold_lo", l1, m_lo);
      end
      check_int("rnd_busy", cyc, e_cyc);
      check32("rnd_hi", hi, e_hi);
      check32("rnd_lo", lo, e_lo);
      m_hi = e_hi; m_lo = e_lo;
    end

    // Make sure hi/lo are nonzero before the abort so the clear is visible.
    issue(3'd4, 32'hA5A5A5A5, 32'h0, cyc, h1, l1);
    issue(3'd5, 32'h5A5A5A5A, 32'h0, cyc, h1, l1);

    // Asynchronous reset on busy cycle 4 of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_int("abort_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check_int("abort_busy", int'(busy), 0);
    check32("abort_hi", hi, 32'h0);
    check32("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_int("abort_late_busy", int'(busy), 0);
    check32("abort_late_hi", hi, 32'h0);
    check32("abort_late_lo", lo, 32'h0);

    // Issue on the first edge after reset release.
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; op = 3'd5; a = 32'hC0FFEE11;
    @(negedge clk);
    start = 1'b0;
    check32("post_reset_mtlo", lo, 32'hC0FFEE11);
    check32("post_reset_hi", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width.
REQ-002 Parameter MULT_CYCLES, default 5: busy duration of multiply ops, legal range 1..63.
REQ-003 Parameter DIV_CYCLES, default 10: busy duration of divide ops, legal range 1..63.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  issue strobe, sampled on the rising edge.
REQ-007 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
REQ-008 a  input  WIDTH  rs operand: multiplicand, dividend or MTHI/MTLO source.
REQ-009 b  input  WIDTH  rt operand: multiplier or divisor.
REQ-010 busy  output  1  high while a multiply or divide is in flight.
REQ-011 hi  output  WIDTH  HI register, driven directly from a flop.
REQ-012 lo  output  WIDTH  LO register, driven directly from a flop.

Function
REQ-013 An issue is accepted only on an edge where start=1 and busy=0; start while busy=1 is ignored with no state change.
REQ-014 Accepted op 0-3, 6 or 7: the unit latches a, b and op, loads the counter, and sets busy=1 from the next cycle.
REQ-015 Busy duration: MULT_CYCLES cycles for ops 0, 1, 6 and 7; DIV_CYCLES cycles for ops 2 and 3.
REQ-016 hi/lo update on the same edge that drops busy; hi/lo hold their old values while busy=1.
REQ-017 MULT: {hi,lo} = signed a*b as a 2*WIDTH product; MULTU: unsigned product.
REQ-018 DIV: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign; DIVU: unsigned quotient and remainder.
REQ-019 Divisor zero: the unit still runs busy for DIV_CYCLES; hi and lo remain unchanged.
REQ-020 Signed DIV with a = -2^(WIDTH-1) and b = -1: lo = -2^(WIDTH-1), hi = 0.
REQ-021 MTHI/MTLO: hi or lo takes a on the accepting edge, busy stays 0, and the other register is untouched.
REQ-022 Invalid ops with the macro absent (6 and 7) are accepted as no-ops: no busy, no register change.
REQ-023 State machine: IDLE -> (accepted op 0-3, 6 or 7) RUN -> (counter reaches 1) DONE-edge -> IDLE; busy=1 exactly in RUN.
REQ-024 Back-to-back issue is allowed: start on the first cycle with busy=0 is accepted and sees the updated hi/lo.

Reset
REQ-025 reset=1 immediately forces busy=0, hi=0, lo=0, the counter to 0 and the state to IDLE, independent of clk.
REQ-026 Reset mid-operation aborts the operation; no partial result is ever written to hi/lo.
REQ-027 Issue is accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MDU_MADD_EN: when defined, op 6 MADD sets {hi,lo} += signed a*b and op 7 MADDU sets {hi,lo} += unsigned a*b, modulo 2^(2*WIDTH), with MULT_CYCLES latency.
REQ-029 MDU_MADD_EN undefined: ops 6 and 7 behave per REQ-022, and the accumulate adder is not synthesised.

Verification
REQ-030 Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=7, b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-032 MULTU a=0x12345678, b=0x9ABCDEF0; start=1 with op=4 (MTHI) asserted on busy cycle 2 -> MTHI ignored, final hi=0x0B00EA4E, lo=0x242D2080.
REQ-033 MTLO a=0xDEADBEEF, then MTHI a=0x1 on consecutive cycles -> busy never rises, lo=0xDEADBEEF, hi=0x1.
REQ-034 Start DIV, assert reset asynchronously on busy cycle 4 -> busy=0, hi=lo=0 at once, with no later update.
REQ-035 With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0; without the macro, the same stimulus leaves hi=0, lo=0xFFFFFFFF and busy=0.
